instruction_decoder: RTL and testbench



---
 rtl/instruction_decoder_if.sv | 22 ++
 rtl/instruction_decoder.sv | 73 +++++++
 tb/tb_instruction_decoder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_decoder_if.sv
// Sequencer-to-decoder bundle: phase-2 enable, T-state and opcode in,
// registered control word out.
interface instruction_decoder_if;
    logic       clk_ph2;
    logic [2:0] cycle;
    logic [7:0] ir;
    logic [7:0] ctrl_sig1;

    modport master (
        output clk_ph2,
        output cycle,
        output ir,
        input  ctrl_sig1
    );

    modport slave (
        input  clk_ph2,
        input  cycle,
        input  ir,
        output ctrl_sig1
    );
endinterface

// File: rtl/instruction_decoder.sv
// Registered control-word decoder: (ir, cycle) -> datapath strobes,
// updated only on sys_clock edges where clk_ph2 is high.
module instruction_decoder (
    input  logic                        sys_clock,
    input  logic                        rst,
    instruction_decoder_if.slave        bus
);
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_ALU   = 8'h03;
    localparam logic [7:0] OP_JUMP  = 8'h04;
    localparam logic [7:0] OP_HALT  = 8'h07;

    localparam logic [7:0] C_ACC_LOAD = 8'h01;
    localparam logic [7:0] C_ACC_OUT  = 8'h02;
    localparam logic [7:0] C_ALU_EN   = 8'h04;
    localparam logic [7:0] C_MEM_RD   = 8'h08;
    localparam logic [7:0] C_PC_INC   = 8'h10;
    localparam logic [7:0] C_MEM_WR   = 8'h20;
    localparam logic [7:0] C_PC_LOAD  = 8'h40;
    localparam logic [7:0] C_HALT     = 8'h80;

    logic [7:0] ctrl_next;
    logic [7:0] ctrl_q;

    // Unlisted opcodes and T-states clear the word rather than hold it.
    always_comb begin
        ctrl_next = 8'h00;
        case (bus.ir)
            OP_NOP: ctrl_next = 8'h00;
            OP_LOAD: begin
                case (bus.cycle)
                    3'd0:    ctrl_next = C_ACC_LOAD;
                    3'd1:    ctrl_next = C_MEM_RD | C_PC_INC;
                    default: ctrl_next = 8'h00;
                endcase
            end
            OP_STORE: begin
                case (bus.cycle)
                    3'd0:    ctrl_next = C_ACC_OUT;
                    3'd1:    ctrl_next = C_MEM_WR;
                    default: ctrl_next = 8'h00;
                endcase
            end
            OP_ALU: begin
                case (bus.cycle)
                    3'd0:    ctrl_next = C_ALU_EN;
                    3'd1:    ctrl_next = C_ACC_LOAD;
                    default: ctrl_next = 8'h00;
                endcase
            end
            OP_JUMP: begin
                case (bus.cycle)
                    3'd0:    ctrl_next = C_PC_LOAD;
                    default: ctrl_next = 8'h00;
                endcase
            end
            OP_HALT: ctrl_next = C_HALT;
            default: ctrl_next = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (!rst) begin
            ctrl_q <= 8'h00;
        end else if (bus.clk_ph2) begin
            ctrl_q <= ctrl_next;
        end
    end

    assign bus.ctrl_sig1 = ctrl_q;
endmodule

// File: tb/tb_instruction_decoder.sv
// Directed-vector bench for instruction_decoder.
// Inputs change 1 time unit after the rising edge; outputs checked there too.
module tb_instruction_decoder;
    logic sys_clock;
    logic rst;
    int   n_cmp;
    int   n_bad;

    instruction_decoder_if bus ();

    instruction_decoder dut (
        .sys_clock (sys_clock),
        .rst       (rst),
        .bus       (bus)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] cy,
                         input logic ph2);
        bus.ir      = op;
        bus.cycle   = cy;
        bus.clk_ph2 = ph2;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(8'h01, 3'd0, 1'b1);
        tick();
        tick();
        n_cmp++;
        if (bus.ctrl_sig1 !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_hold: got %h want %h", bus.ctrl_sig1, 8'h00);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (bus.ctrl_sig1 !== 8'h01) begin
            n_bad++;
            $display("FAIL reset_release: got %h want %h", bus.ctrl_sig1, 8'h01);
        end
    endtask

    task automatic test_load();
        logic [7:0] exp_v [3];
        exp_v = '{8'h01, 8'h18, 8'h00};
        for (int i = 0; i < 3; i++) begin
            drive(8'h01, i[2:0], 1'b1);
            tick();
            n_cmp++;
            if (bus.ctrl_sig1 !== exp_v[i]) begin
                n_bad++;
                $display("FAIL load_c%0d: got %h want %h",
                         i, bus.ctrl_sig1, exp_v[i]);
            end
        end
    endtask

    task automatic test_store_alu();
        logic [7:0] op_v  [3];
        logic [2:0] cy_v  [3];
        logic [7:0] exp_v [3];
        op_v  = '{8'h02, 8'h03, 8'h03};
        cy_v  = '{3'd0, 3'd0, 3'd1};
        exp_v = '{8'h02, 8'h04, 8'h01};
        for (int i = 0; i < 3; i++) begin
            drive(op_v[i], cy_v[i], 1'b1);
            tick();
            n_cmp++;
            if (bus.ctrl_sig1 !== exp_v[i]) begin
                n_bad++;
                $display("FAIL store_alu op%h c%0d: got %h want %h",
                         op_v[i], cy_v[i], bus.ctrl_sig1, exp_v[i]);
            end
        end
    endtask

    task automatic test_undefined_halt();
        drive(8'h03, 3'd0, 1'b1);
        tick();
        n_cmp++;
        if (bus.ctrl_sig1 !== 8'h04) begin
            n_bad++;
            $display("FAIL undef_prior: got %h want %h", bus.ctrl_sig1, 8'h04);
        end
        drive(8'hFF, 3'd0, 1'b1);
        tick();
        n_cmp++;
        if (bus.ctrl_sig1 !== 8'h00) begin
            n_bad++;
            $display("FAIL undef_ff: got %h want %h", bus.ctrl_sig1, 8'h00);
        end
        for (int c = 0; c < 8; c += 3) begin
            drive(8'h07, c[2:0], 1'b1);
            tick();
            n_cmp++;
            if (bus.ctrl_sig1 !== 8'h80) begin
                n_bad++;
                $display("FAIL halt_c%0d: got %h want %h",
                         c, bus.ctrl_sig1, 8'h80);
            end
        end
    endtask

    task automatic test_enable_gating();
        drive(8'h01, 3'd1, 1'b1);
        tick();
        n_cmp++;
        if (bus.ctrl_sig1 !== 8'h18) begin
            n_bad++;
            $display("FAIL gate_setup: got %h want %h", bus.ctrl_sig1, 8'h18);
        end
        drive(8'h02, 3'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (bus.ctrl_sig1 !== 8'h18) begin
                n_bad++;
                $display("FAIL gate_hold%0d: got %h want %h",
                         k, bus.ctrl_sig1, 8'h18);
            end
        end
        bus.clk_ph2 = 1'b1;
        tick();
        n_cmp++;
        if (bus.ctrl_sig1 !== 8'h02) begin
            n_bad++;
            $display("FAIL gate_release: got %h want %h", bus.ctrl_sig1, 8'h02);
        end
    endtask

    task automatic test_reset_mid();
        drive(8'h07, 3'd2, 1'b1);
        tick();
        n_cmp++;
        if (bus.ctrl_sig1 !== 8'h80) begin
            n_bad++;
            $display("FAIL midrst_setup: got %h want %h", bus.ctrl_sig1, 8'h80);
        end
        bus.clk_ph2 = 1'b0;
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.ctrl_sig1 !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_clear: got %h want %h", bus.ctrl_sig1, 8'h00);
        end
        rst = 1'b1;
        drive(8'h04, 3'd0, 1'b1);
        tick();
        n_cmp++;
        if (bus.ctrl_sig1 !== 8'h40) begin
            n_bad++;
            $display("FAIL midrst_resume: got %h want %h", bus.ctrl_sig1, 8'h40);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] op_v  [10];
        logic [2:0] cy_v  [10];
        logic [7:0] exp_v [10];
        op_v  = '{8'h04, 8'h04, 8'h02, 8'h02, 8'h00,
                  8'h05, 8'h06, 8'h08, 8'h03, 8'h01};
        cy_v  = '{3'd0, 3'd1, 3'd1, 3'd7, 3'd0,
                  3'd0, 3'd1, 3'd0, 3'd2, 3'd7};
        exp_v = '{8'h40, 8'h00, 8'h20, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 10; i++) begin
            drive(op_v[i], cy_v[i], 1'b1);
            tick();
            n_cmp++;
            if (bus.ctrl_sig1 !== exp_v[i]) begin
                n_bad++;
                $display("FAIL b2b op%h c%0d: got %h want %h",
                         op_v[i], cy_v[i], bus.ctrl_sig1, exp_v[i]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        drive(8'h00, 3'd0, 1'b0);
        test_reset();
        test_load();
        test_store_alu();
        test_undefined_halt();
        test_enable_gating();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
